// File: rtl/hex_scan_disp_pkg.sv
// Shared widths, mode codes, segment constants and the hex seg7 table for the
// scanned 7-segment display path.
package hex_scan_disp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DIG_N  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_A = 3'b000;
  localparam logic [MODE_W-1:0] MODE_B = 3'b001;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [DIG_N-1:0] AN_OFF    = 8'hFF;

  // Active-low {dp,g..a} per hex value; entry 0 sits in the low byte.
  localparam logic [16*SEG_W-1:0] SEG7_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Per-frame snapshot of the shown word and its cursor mask.
  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [DIG_N-1:0]  mask;
  } disp_snap_t;

endpackage

// File: rtl/hex_scan_disp_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment (g..a) decoder.
module hex_to_seg7
  import hex_scan_disp_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [6:0]       seg_c
);

  assign seg_c = SEG7_TABLE[{nib, 3'b000} +: 7];

endmodule

// File: rtl/hex_scan_disp.sv
// Multiplexed 8-digit common-anode hex display with per-frame snapshot and
// cursor-digit blinking.
module hex_scan_disp
  import hex_scan_disp_pkg::*;
#(
  parameter int unsigned SCAN_W     = 17,
  parameter int unsigned BLINK_FRMS = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   Ai,
  input  logic [WORD_W-1:0]   Bi,
  input  logic [WORD_W-1:0]   Ci,
  input  logic [4:0]          Dctr,
  input  logic [DIG_N-1:0]    blink,
  output logic [DIG_N-1:0]    AN,
  output logic [SEG_W-1:0]    SEGMENT
);

  localparam int unsigned FRM_W = (BLINK_FRMS > 1) ? $clog2(BLINK_FRMS) : 1;

  logic [SCAN_W-1:0] presc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [FRM_W-1:0]  frm_q;
  logic              phase_q;
  disp_snap_t        snap_q;
  logic [DIG_N-1:0]  an_q;
  logic [SEG_W-1:0]  seg_q;

  logic              tick_c;
  logic              frame_c;
  logic [WORD_W-1:0] word_sel_c;
  logic [NIB_W-1:0]  nib_c;
  logic [6:0]        seg7_c;
  logic              unused_dctr_c;

  assign tick_c        = &presc_q;
  assign frame_c       = tick_c && (idx_q == IDX_W'(DIG_N - 1));
  assign unused_dctr_c = ^Dctr[1:0];

  // Word source for the next snapshot.
  always_comb begin
    word_sel_c = Ci;
    case (Dctr[4:2])
      MODE_A:  word_sel_c = Ai;
      MODE_B:  word_sel_c = Bi;
      default: word_sel_c = Ci;
    endcase
  end

  // Scan timing: prescaler, digit index, blink frame counter and phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_q + SCAN_W'(1);
      if (tick_c) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (frame_c) begin
        if (frm_q == FRM_W'(BLINK_FRMS - 1)) begin
          frm_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          frm_q <= frm_q + FRM_W'(1);
        end
      end
    end
  end

  // Data is latched only on frame boundaries so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (frame_c) begin
      snap_q.word <= word_sel_c;
      snap_q.mask <= blink;
    end
  end

  assign nib_c = snap_q.word[{idx_q, 2'b00} +: NIB_W];

  hex_to_seg7 u_dec (
    .nib   (nib_c),
    .seg_c (seg7_c)
  );

  // Output registers; a blanked digit keeps its anode enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q <= ~(DIG_N'(1) << idx_q);
      if (snap_q.mask[idx_q] && phase_q) begin
        seg_q <= SEG_BLANK;
      end else begin
        seg_q <= {1'b1, seg7_c};
      end
    end
  end

  assign AN      = an_q;
  assign SEGMENT = seg_q;

endmodule

// File: tb/tb_hex_scan_disp.sv
// Directed bench for hex_scan_disp with a 4-clk slot and 32-clk frame.
module tb_hex_scan_disp;

  logic        clk;
  logic        rst;
  logic [31:0] Ai;
  logic [31:0] Bi;
  logic [31:0] Ci;
  logic [4:0]  Dctr;
  logic [7:0]  blink;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;

  int checks;
  int failures;
  int cyc;

  hex_scan_disp #(
    .SCAN_W     (2),
    .BLINK_FRMS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Ai      (Ai),
    .Bi      (Bi),
    .Ci      (Ci),
    .Dctr    (Dctr),
    .blink   (blink),
    .AN      (AN),
    .SEGMENT (SEGMENT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges counted since the last reset release; slot d of frame f is
  // sampled on the negedge where cyc == 32*f + 4*d + 2.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  blink;
    logic [63:0] exp;   // digit0 in the low byte
  } vec_t;

  localparam logic [63:0] EXP_A    = 64'h80F8_8292_99B0_A4F9;
  localparam logic [63:0] EXP_A_B2 = 64'h80F8_8292_99FF_A4F9;
  localparam logic [63:0] EXP_B    = 64'hF9A4_B099_9282_F880;
  localparam logic [63:0] EXP_B_BL = 64'hFFA4_B099_9282_F8FF;
  localparam logic [63:0] EXP_C    = 64'h8E86_A1C6_8388_90C0;
  localparam logic [63:0] EXP_ZERO = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] EXP_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_slot(input int f, input int d, input logic [7:0] exp_seg, input string tag);
    int target;
    logic [7:0] exp_an;
    target = 32 * f + 4 * d + 2;
    while (cyc != target) begin
      if (cyc > target) begin
        checks++;
        failures++;
        $display("FAIL %s slot timing cyc=%0d want=%0d", tag, cyc, target);
        return;
      end
      @(negedge clk);
    end
    exp_an = ~(8'(1) << d);
    check8($sformatf("%s f%0d d%0d AN", tag, f, d), AN, exp_an);
    check8($sformatf("%s f%0d d%0d SEG", tag, f, d), SEGMENT, exp_seg);
  endtask

  task automatic check_frame(input int f, input logic [63:0] exp, input string tag);
    for (int d = 0; d < 8; d++) check_slot(f, d, exp[8*d +: 8], tag);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{3'd0, 8'h00, EXP_A};
    vecs[1] = '{3'd1, 8'h00, EXP_B};
    vecs[2] = '{3'd3, 8'h00, EXP_C};
    vecs[3] = '{3'd0, 8'h04, EXP_A};
    vecs[4] = '{3'd0, 8'h04, EXP_A};
    vecs[5] = '{3'd0, 8'h04, EXP_A_B2};
    vecs[6] = '{3'd0, 8'h04, EXP_A_B2};
    vecs[7] = '{3'd7, 8'h81, EXP_C};
    vecs[8] = '{3'd1, 8'h81, EXP_B};
    vecs[9] = '{3'd1, 8'h81, EXP_B_BL};

    checks   = 0;
    failures = 0;
    Ai    = 32'h8765_4321;
    Bi    = 32'h1234_5678;
    Ci    = 32'hFEDC_BA90;
    Dctr  = {vecs[0].mode, 2'b00};
    blink = vecs[0].blink;
    rst   = 1'b1;

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("reset AN", AN, 8'hFF);
    check8("reset SEG", SEGMENT, 8'hFF);
    rst = 1'b0;

    // First frame shows the empty snapshot
    check_frame(0, EXP_ZERO, "first");

    // Vector i lands in frame i+1; the next vector is applied mid-frame
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 8; d++) begin
        if (d == 4 && i < 9) begin
          Dctr  = {vecs[i+1].mode, 2'(i)};
          blink = vecs[i+1].blink;
        end
        check_slot(i + 1, d, vecs[i].exp[8*d +: 8], $sformatf("vec%0d", i));
      end
    end

    // Async reset pulsed between edges at index 5, phase 1
    check_slot(11, 5, 8'hB0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check8("async rst AN", AN, 8'hFF);
    check8("async rst SEG", SEGMENT, 8'hFF);
    #1 rst = 1'b0;
    blink = 8'hFF;

    // Scan restarts at digit 0 with phase 0, then multi-hot blanking
    check_frame(0, EXP_ZERO, "restart");
    check_frame(1, EXP_B, "phase0");
    check_frame(2, EXP_ALL, "multihot");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
